// File: rtl/ex_mem_latch_if.sv
// EX->MEM pipeline register bundle: EX-side capture inputs plus registered MEM-side outputs.
// Latency: none (signal bundle only).
// Backpressure: stall/flush travel with the bundle; there is no ready/valid handshake.
interface ex_mem_latch_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    // Pipeline control
    logic          stall;
    logic          flush;

    // EX-stage capture inputs
    logic          ex_valid;
    logic [DW-1:0] ex_npc;
    logic [DW-1:0] ex_sext_imm;
    logic [DW-1:0] ex_alu_result;
    logic          ex_zero;
    logic [DW-1:0] ex_rdata2;
    logic [RW-1:0] ex_wreg;
    logic [4:0]    ex_ctl;          // {branch, memread, memwrite, regwrite, memtoreg}

    // MEM-stage registered outputs
    logic          mem_valid;
    logic [DW-1:0] add_in1;
    logic [DW-1:0] add_in2;
    logic [DW-1:0] mem_alu_result;
    logic [DW-1:0] mem_rdata2;
    logic [RW-1:0] mem_wreg;
    logic [3:0]    mem_ctl;         // {memread, memwrite, regwrite, memtoreg}
    logic          mem_pcsrc;

    // EX side: drives the capture inputs, observes the MEM slot
    modport master (
        output stall, flush,
        output ex_valid, ex_npc, ex_sext_imm, ex_alu_result, ex_zero,
        output ex_rdata2, ex_wreg, ex_ctl,
        input  mem_valid, add_in1, add_in2, mem_alu_result, mem_rdata2,
        input  mem_wreg, mem_ctl, mem_pcsrc
    );

    // Latch side: consumes the capture inputs, drives the MEM slot
    modport slave (
        input  stall, flush,
        input  ex_valid, ex_npc, ex_sext_imm, ex_alu_result, ex_zero,
        input  ex_rdata2, ex_wreg, ex_ctl,
        output mem_valid, add_in1, add_in2, mem_alu_result, mem_rdata2,
        output mem_wreg, mem_ctl, mem_pcsrc
    );
endinterface

// File: rtl/ex_mem_latch.sv
// EX->MEM pipeline register; presents branch-adder operands and resolves pcsrc.
// Latency: exactly 1 cycle from EX inputs to MEM outputs; no combinational input->output path.
// Backpressure: stall holds every register; flush (wins over stall) loads a zeroed bubble.
module ex_mem_latch #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic           clk,
    input  logic           rst,
    ex_mem_latch_if.slave  bus
);

    localparam int CTL_BRANCH = 4;

    logic          valid_q,  valid_d;
    logic [DW-1:0] npc_q,    npc_d;
    logic [DW-1:0] off_q,    off_d;
    logic [DW-1:0] alu_q,    alu_d;
    logic [DW-1:0] rdata2_q, rdata2_d;
    logic [RW-1:0] wreg_q,   wreg_d;
    logic [3:0]    ctl_q,    ctl_d;
    logic          pcsrc_q,  pcsrc_d;

    // Next-state selection: flush beats stall, stall beats a normal load
    always_comb begin
        valid_d  = valid_q;
        npc_d    = npc_q;
        off_d    = off_q;
        alu_d    = alu_q;
        rdata2_d = rdata2_q;
        wreg_d   = wreg_q;
        ctl_d    = ctl_q;
        pcsrc_d  = pcsrc_q;
        if (bus.flush) begin
            // Zero the datapath too so a flushed slot is fully deterministic
            valid_d  = 1'b0;
            npc_d    = '0;
            off_d    = '0;
            alu_d    = '0;
            rdata2_d = '0;
            wreg_d   = '0;
            ctl_d    = '0;
            pcsrc_d  = 1'b0;
        end else if (!bus.stall) begin
            // Datapath is captured even for a bubble; control is gated by ex_valid
            valid_d  = bus.ex_valid;
            npc_d    = bus.ex_npc;
            off_d    = {bus.ex_sext_imm[DW-3:0], 2'b00};
            alu_d    = bus.ex_alu_result;
            rdata2_d = bus.ex_rdata2;
            wreg_d   = bus.ex_wreg;
            ctl_d    = bus.ex_valid ? bus.ex_ctl[3:0] : 4'b0000;
            pcsrc_d  = bus.ex_valid & bus.ex_ctl[CTL_BRANCH] & bus.ex_zero;
        end
    end

    // Slot registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            npc_q    <= '0;
            off_q    <= '0;
            alu_q    <= '0;
            rdata2_q <= '0;
            wreg_q   <= '0;
            ctl_q    <= '0;
            pcsrc_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            npc_q    <= npc_d;
            off_q    <= off_d;
            alu_q    <= alu_d;
            rdata2_q <= rdata2_d;
            wreg_q   <= wreg_d;
            ctl_q    <= ctl_d;
            pcsrc_q  <= pcsrc_d;
        end
    end

    // Outputs come straight from flops
    assign bus.mem_valid      = valid_q;
    assign bus.add_in1        = npc_q;
    assign bus.add_in2        = off_q;
    assign bus.mem_alu_result = alu_q;
    assign bus.mem_rdata2     = rdata2_q;
    assign bus.mem_wreg       = wreg_q;
    assign bus.mem_ctl        = ctl_q;
    assign bus.mem_pcsrc      = pcsrc_q;

endmodule
